// File: rtl/main_memory_if.sv
// Memory-side bus between the cache (master) and main memory (slave).
interface main_memory_if;
    logic [15:0] mem_addr;
    logic        mem_ren;
    logic        mem_wen;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_data_valid;

    modport master (
        output mem_addr, mem_ren, mem_wen, mem_wdata,
        input  mem_rdata, mem_data_valid
    );

    modport slave (
        input  mem_addr, mem_ren, mem_wen, mem_wdata,
        output mem_rdata, mem_data_valid
    );
endinterface

// File: rtl/main_memory.sv
// Word-addressed main memory with posted writes and a fixed-latency,
// fully pipelined read return path.
module main_memory #(
    parameter int LATENCY        = 4,
    parameter int WORD_ADDR_BITS = 15
) (
    input logic           clk,
    input logic           rst_n,
    main_memory_if.slave  mem_if
);
    localparam int DEPTH = 1 << WORD_ADDR_BITS;

    logic [15:0]               array_q [DEPTH];
    logic [WORD_ADDR_BITS-1:0] widx;
    logic                      rd_acc;
    logic [LATENCY-1:0]        vld_q;
    logic [LATENCY-1:0][15:0]  data_q;
    logic                      unused_addr_bits;

    assign widx   = mem_if.mem_addr[WORD_ADDR_BITS:1];
    // A write wins a collision; the colliding read is dropped.
    assign rd_acc = mem_if.mem_ren & ~mem_if.mem_wen;

    generate
        if (WORD_ADDR_BITS < 15) begin : g_alias
            assign unused_addr_bits = ^{mem_if.mem_addr[15:WORD_ADDR_BITS+1], mem_if.mem_addr[0]};
        end else begin : g_full
            assign unused_addr_bits = mem_if.mem_addr[0];
        end
    endgenerate

    // Storage is never reset.
    always_ff @(posedge clk) begin
        if (mem_if.mem_wen) array_q[widx] <= mem_if.mem_wdata;
    end

    // Data stages only advance behind a valid bit, so the last stage keeps
    // the most recently returned word while no strobe is presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            data_q <= '0;
        end else begin
            vld_q[0] <= rd_acc;
            if (rd_acc) data_q[0] <= array_q[widx];
            for (int k = 1; k < LATENCY; k++) begin
                vld_q[k] <= vld_q[k-1];
                if (vld_q[k-1]) data_q[k] <= data_q[k-1];
            end
        end
    end

    assign mem_if.mem_data_valid = vld_q[LATENCY-1];
    assign mem_if.mem_rdata      = data_q[LATENCY-1];
endmodule

// File: tb/tb_main_memory.sv
// Scoreboard bench for main_memory: a full-width instance and an
// 8-bit-word-address instance used for the alias case.
module tb_main_memory;
    localparam int L = 4;

    typedef struct {
        int          cyc;
        logic [15:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t qa[$];
    exp_t qb[$];

    main_memory_if ifa();
    main_memory_if ifb();

    main_memory #(.LATENCY(L), .WORD_ADDR_BITS(15)) u_a (.clk(clk), .rst_n(rst_n), .mem_if(ifa));
    main_memory #(.LATENCY(L), .WORD_ADDR_BITS(8))  u_b (.clk(clk), .rst_n(rst_n), .mem_if(ifb));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Monitors: every strobe must match the head of its queue in data and cycle.
    always @(negedge clk) begin
        if (rst_n && ifa.mem_data_valid) begin
            checks++;
            if (qa.size() == 0) begin
                errors++;
                $display("FAIL a_unexpected_strobe cyc=%0d rdata=%h", cyc, ifa.mem_rdata);
            end else begin
                exp_t e;
                e = qa.pop_front();
                if (ifa.mem_rdata !== e.data) begin
                    errors++;
                    $display("FAIL a_rdata got=%h exp=%h", ifa.mem_rdata, e.data);
                end
                checks++;
                if (cyc != e.cyc) begin
                    errors++;
                    $display("FAIL a_latency got_cyc=%0d exp_cyc=%0d", cyc, e.cyc);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && ifb.mem_data_valid) begin
            checks++;
            if (qb.size() == 0) begin
                errors++;
                $display("FAIL b_unexpected_strobe cyc=%0d rdata=%h", cyc, ifb.mem_rdata);
            end else begin
                exp_t e;
                e = qb.pop_front();
                if (ifb.mem_rdata !== e.data) begin
                    errors++;
                    $display("FAIL b_rdata got=%h exp=%h", ifb.mem_rdata, e.data);
                end
                checks++;
                if (cyc != e.cyc) begin
                    errors++;
                    $display("FAIL b_latency got_cyc=%0d exp_cyc=%0d", cyc, e.cyc);
                end
            end
        end
    end

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // One bus cycle on instance A, driven just after a falling edge.
    task automatic op_a(input logic ren, input logic wen, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [15:0] exp);
        ifa.mem_ren = ren; ifa.mem_wen = wen; ifa.mem_addr = addr; ifa.mem_wdata = wdata;
        if (ren && !wen) qa.push_back('{cyc + L, exp});
        @(negedge clk);
        ifa.mem_ren = 1'b0; ifa.mem_wen = 1'b0;
    endtask

    task automatic op_b(input logic ren, input logic wen, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [15:0] exp);
        ifb.mem_ren = ren; ifb.mem_wen = wen; ifb.mem_addr = addr; ifb.mem_wdata = wdata;
        if (ren && !wen) qb.push_back('{cyc + L, exp});
        @(negedge clk);
        ifb.mem_ren = 1'b0; ifb.mem_wen = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        ifa.mem_ren = 0; ifa.mem_wen = 0; ifa.mem_addr = 0; ifa.mem_wdata = 0;
        ifb.mem_ren = 0; ifb.mem_wen = 0; ifb.mem_addr = 0; ifb.mem_wdata = 0;

        // Reset values held for 3 cycles and on the first cycle after release.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_valid", {15'd0, ifa.mem_data_valid}, 16'h0000);
            check("rst_rdata", ifa.mem_rdata, 16'h0000);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_valid", {15'd0, ifa.mem_data_valid}, 16'h0000);
        check("post_rst_rdata", ifa.mem_rdata, 16'h0000);

        // Single read, bit 0 of the byte address ignored.
        op_a(0, 1, 16'h0010, 16'hBEEF, 16'h0);
        op_a(1, 0, 16'h0011, 16'h0, 16'hBEEF);
        idle(L + 2);

        // Burst fill.
        for (int i = 0; i < 8; i++) op_a(0, 1, 16'h0200 + 16'(2 * i), 16'h1000 + 16'(i), 16'h0);
        for (int i = 0; i < 8; i++) op_a(1, 0, 16'h0200 + 16'(2 * i), 16'h0, 16'h1000 + 16'(i));
        idle(L + 3);
        check("rdata_hold", ifa.mem_rdata, 16'h1007);

        // Write between two reads of the same word.
        op_a(0, 1, 16'h0040, 16'hAAAA, 16'h0);
        idle(2);
        op_a(1, 0, 16'h0040, 16'h0, 16'hAAAA);
        op_a(0, 1, 16'h0040, 16'h5555, 16'h0);
        op_a(1, 0, 16'h0040, 16'h0, 16'h5555);
        idle(L + 2);

        // Collision: write performed, read dropped; alias on the narrow instance.
        op_a(1, 1, 16'h0100, 16'h1234, 16'h0);
        op_b(1, 1, 16'h0100, 16'h1234, 16'h0);
        idle(L + 2);
        op_a(1, 0, 16'h0100, 16'h0, 16'h1234);
        op_b(1, 0, 16'h0300, 16'h0, 16'h1234);
        idle(L + 3);
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL queues_drained got=%0d/%0d exp=0/0", qa.size(), qb.size());
        end

        // Reset mid-burst: 4th request in flight, first strobe just presented.
        for (int i = 0; i < 3; i++) op_a(1, 0, 16'h0200 + 16'(2 * i), 16'h0, 16'h0);
        ifa.mem_ren = 1'b1; ifa.mem_addr = 16'h0206;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        qa.delete();
        ifa.mem_ren = 1'b0;
        #1;
        check("midrst_valid", {15'd0, ifa.mem_data_valid}, 16'h0000);
        check("midrst_rdata", ifa.mem_rdata, 16'h0000);
        idle(2);
        rst_n = 1'b1;
        idle(L + 6);
        checks++;
        if (qa.size() != 0) begin
            errors++;
            $display("FAIL midrst_queue got=%0d exp=0", qa.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/main_memory.md
# main_memory

Multi-cycle main memory that answers the cache's memory-side port: it accepts word reads and writes on the `mem_*` bus and returns read data a fixed number of cycles later with a one-cycle `mem_data_valid` strobe. Reads are fully pipelined, so a cache fill can issue one address per cycle and receive one word per cycle after the initial latency. Writes are posted and take effect at the accepting clock edge.

## Interface
- `LATENCY`, 4: cycles from read acceptance to `mem_data_valid`; legal range 1–16.
- `WORD_ADDR_BITS`, 15: word-address width; depth = 2^`WORD_ADDR_BITS` 16-bit words.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `mem_addr` in 16: byte address; bit 0 ignored; word index = `mem_addr[WORD_ADDR_BITS:1]`; higher bits ignored (aliasing).
- `mem_ren` in 1: read request, sampled every cycle; one request per high cycle.
- `mem_wen` in 1: write request, sampled every cycle.
- `mem_wdata` in 16: write data, sampled with `mem_wen`.
- `mem_rdata` out 16: read data; meaningful when `mem_data_valid` = 1.
- `mem_data_valid` out 1: one-cycle strobe per returned read word.

## Operation
- Storage: 2^`WORD_ADDR_BITS` × 16-bit array, not cleared by reset; uninitialised contents are X in simulation.
- No backpressure and no ready signal: every cycle with `mem_ren` = 1 is accepted.
- Read pipeline: `LATENCY`-stage shift register of {valid, data}.
  - On acceptance, the array word at the sampled address is captured into stage 0.
  - Stages advance every cycle; the last stage drives the outputs.
- In-order return, one word per cycle max; back-to-back reads yield back-to-back valid strobes.
- Write: if `mem_wen` = 1 at a rising edge, `array[word index] <= mem_wdata` at that edge.
- Simultaneous `mem_ren` and `mem_wen`: the write is performed and the read is dropped (no strobe is ever produced for it). The cache never drives both; this is the defined fallback.
- Read-after-write: a read accepted in any cycle after the write edge returns the new data.
- Write during in-flight read: the in-flight read returns the value captured at its acceptance, not the new data.
- `mem_rdata` holds the last returned word while `mem_data_valid` = 0.
- Address wrap: addresses differing only above bit `WORD_ADDR_BITS` alias to the same word.

## Timing
- Reset (`rst_n` low, async): all pipeline valid bits = 0, `mem_data_valid` = 0, `mem_rdata` = 16'h0000. Array contents are untouched.
- Reset mid-operation: all in-flight reads are discarded, with no strobes after reset. A write at the same edge that reset asserts is not guaranteed.
- First accepted edge after reset deassertion: a request at edge N produces `mem_data_valid` = 1 during the cycle following edge N+`LATENCY`-1. That is exactly `LATENCY` cycles after the request cycle.
- `LATENCY` = 1: data is registered out the cycle after the request, with no combinational path from `mem_addr` to `mem_rdata`.
- Throughput: 1 read per cycle sustained; 1 write per cycle sustained; no turnaround penalty between reads and writes.
- Outputs are registered only.

## Test plan
- Reset values: hold `rst_n` = 0 for 3 cycles → `mem_data_valid` = 0 and `mem_rdata` = 0000 throughout and on the first cycle after release.
- Single read, `LATENCY` = 4:
  - Write 16'hBEEF to byte address 0x0010, then read 0x0011 at cycle T.
  - Required: `mem_data_valid` high only at T+4, with `mem_rdata` = BEEF (bit 0 ignored).
- Burst fill:
  - Preload words 0x0200–0x020E (even) with 0x1000+i, then issue 8 consecutive reads 0x0200, 0x0202, … 0x020E.
  - Required: 8 consecutive strobes at T+4 … T+11 with data 1000 … 1007, in order.
- Write hazards:
  - Issue read 0x0040 (old value AAAA), then next cycle write 0x0040 = 5555, then next cycle read 0x0040.
  - Required: first strobe returns AAAA, second returns 5555.
- Collision and alias:
  - Assert `mem_ren` and `mem_wen` together at 0x0100 with data 1234 → no strobe, and the word becomes 1234.
  - With `WORD_ADDR_BITS` = 8, read 0x0300 → returns 1234 via alias.
- Reset mid-burst: start an 8-read burst, pull `rst_n` low asynchronously after 3 requests → `mem_data_valid` drops immediately and no strobes appear after release.
